// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences datapath loads/stores onto a word-only RAM,
// doing byte/halfword lane extraction on loads and read-modify-write on SB/SH.
module mem_access_unit #(
  parameter bit SIGN_EXT_LOADS = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  ByteSel,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AccessErr,
  output logic [29:0] RamAddr,
  output logic        RamRdEn,
  output logic        RamWrEn,
  output logic [31:0] RamWData,
  input  logic [31:0] RamRData
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_e;
  state_e state_q, state_d;
  logic [31:0] addr_q, addr_d, wword_q, wword_d, rdata_q, rdata_d;
  logic [1:0] sel_q, sel_d;
  logic store_q, store_d, err_q, err_d;
  logic req, accept, err_in, sw_in;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  logic [31:0] ld_word, mask, lane_data, merged;
  // ByteSel: 00/10 word, 01 byte, 11 halfword
  assign req    = MemRead | MemWrite;
  assign accept = (state_q == IDLE) & req;
  assign err_in = (MemRead & MemWrite) | ((ByteSel == 2'b11) & Address[0]) | (~ByteSel[0] & (|Address[1:0]));
  assign sw_in  = MemWrite & ~ByteSel[0];
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = !req ? IDLE : err_in ? DONE : sw_in ? WRITE : READ;
      READ:    state_d = WAIT;
      WAIT:    state_d = store_q ? WRITE : DONE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    RamRdEn   = state_q == READ;
    RamWrEn   = state_q == WRITE;
    AccessErr = (state_q == DONE) & err_q;
    Stall     = Rst & (accept | (state_q == READ) | (state_q == WAIT) | (state_q == WRITE));
  end
  // Little-endian lane selection from the latched low address bits
  assign byte_v  = RamRData[{addr_q[1:0], 3'b000} +: 8];
  assign half_v  = RamRData[{addr_q[1], 4'b0000} +: 16];
  assign ld_word = ~sel_q[0] ? RamRData :
                   sel_q[1]  ? {{16{SIGN_EXT_LOADS & half_v[15]}}, half_v} :
                               {{24{SIGN_EXT_LOADS & byte_v[7]}}, byte_v};
  // Store data replicated into every lane; the mask keeps only the addressed one
  assign mask      = sel_q[1] ? 32'h0000_FFFF << {addr_q[1], 4'b0000} : 32'h0000_00FF << {addr_q[1:0], 3'b000};
  assign lane_data = sel_q[1] ? {2{wword_q[15:0]}} : {4{wword_q[7:0]}};
  assign merged    = (RamRData & ~mask) | (lane_data & mask);
  always_comb begin
    addr_d  = accept ? Address : addr_q;
    sel_d   = accept ? ByteSel : sel_q;
    store_d = accept ? MemWrite : store_q;
    err_d   = accept ? err_in : err_q;
    wword_d = accept ? WriteData : ((state_q == WAIT) & store_q) ? merged : wword_q;
    rdata_d = ((state_q == WAIT) & ~store_q) ? ld_word : rdata_q;
  end
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      addr_q  <= '0;
      sel_q   <= '0;
      store_q <= 1'b0;
      err_q   <= 1'b0;
      wword_q <= '0;
      rdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      store_q <= store_d;
      err_q   <= err_d;
      wword_q <= wword_d;
      rdata_q <= rdata_d;
    end
  end
  assign RamAddr  = addr_q[31:2];
  assign RamWData = wword_q;
  assign ReadData = rdata_q;
endmodule
